// File: rtl/floo_axis_noc_bridge_vc_credit.sv
// Credit-flow-controlled bridge between NumChannels NoC virtual channels and one AXI-Stream link.
// Round-robin data and credit arbiters share a single TX beat register; per-channel RX FIFOs absorb incoming flits.
module floo_axis_noc_bridge_vc_credit #(
    parameter int unsigned NumChannels = 2,
    parameter int unsigned FlitWidth   = 64,
    parameter int unsigned RxFifoDepth = 4,
    localparam int unsigned ChIdW      = ($clog2(NumChannels) > 1) ? $clog2(NumChannels) : 1,
    localparam int unsigned BeatWidth  = FlitWidth + 2 * ChIdW + 2,
    localparam int unsigned CntW       = $clog2(RxFifoDepth + 1)
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NumChannels-1:0]           ch_in_valid_i,
    output logic [NumChannels-1:0]           ch_in_ready_o,
    input  logic [NumChannels*FlitWidth-1:0] ch_in_data_i,
    output logic [NumChannels-1:0]           ch_out_valid_o,
    input  logic [NumChannels-1:0]           ch_out_ready_i,
    output logic [NumChannels*FlitWidth-1:0] ch_out_data_o,
    output logic                             axis_out_tvalid_o,
    input  logic                             axis_out_tready_i,
    output logic [BeatWidth-1:0]             axis_out_tdata_o,
    input  logic                             axis_in_tvalid_i,
    output logic                             axis_in_tready_o,
    input  logic [BeatWidth-1:0]             axis_in_tdata_i,
    output logic                             overflow_o
);

    localparam int unsigned PtrW = ($clog2(RxFifoDepth) > 1) ? $clog2(RxFifoDepth) : 1;

    typedef struct packed {
        logic [FlitWidth-1:0] data;
        logic [ChIdW-1:0]     cred_ch;
        logic                 cred_vld;
        logic [ChIdW-1:0]     flit_ch;
        logic                 flit_vld;
    } beat_t;

    beat_t                tx_q, tx_d, rx_beat;
    logic                 tx_vld_q, overflow_q;
    logic [CntW-1:0]      credit_q [NumChannels];
    logic [CntW-1:0]      pend_q   [NumChannels];
    logic [ChIdW-1:0]     rr_q, crr_q, data_gnt, cred_gnt, d_idx, c_idx;
    logic                 data_gnt_vld, cred_gnt_vld, load, do_data, do_cred, rx_acc;
    logic                 bad_ch, ovf_set;
    logic [NumChannels-1:0] elig, has_pend, cred_inc, cred_dec, cred_sat;
    logic [NumChannels-1:0] pend_dec, push, drop, pop;

    logic [FlitWidth-1:0] fifo_mem   [NumChannels][RxFifoDepth];
    logic [PtrW-1:0]      rd_ptr_q   [NumChannels];
    logic [PtrW-1:0]      wr_ptr_q   [NumChannels];
    logic [CntW-1:0]      fifo_cnt_q [NumChannels];

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(RxFifoDepth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign rx_beat           = axis_in_tdata_i;
    assign rx_acc            = axis_in_tvalid_i && !rst_i;
    assign axis_in_tready_o  = !rst_i;
    assign axis_out_tvalid_o = tx_vld_q;
    assign axis_out_tdata_o  = tx_q;
    assign overflow_o        = overflow_q;
    assign load              = !rst_i && (!tx_vld_q || axis_out_tready_i);
    assign do_data           = load && data_gnt_vld;
    assign do_cred           = load && cred_gnt_vld;

    // Round-robin picks for the data flit and the piggy-backed credit, then beat assembly
    always_comb begin
        data_gnt_vld  = 1'b0;
        data_gnt      = '0;
        cred_gnt_vld  = 1'b0;
        cred_gnt      = '0;
        d_idx         = '0;
        c_idx         = '0;
        tx_d          = '0;
        ch_in_ready_o = '0;
        for (int unsigned i = 0; i < NumChannels; i++) begin
            elig[i]     = ch_in_valid_i[i] && (credit_q[i] != '0);
            has_pend[i] = (pend_q[i] != '0);
        end
        for (int unsigned k = 0; k < NumChannels; k++) begin
            d_idx = ChIdW'((32'(rr_q) + k) % NumChannels);
            c_idx = ChIdW'((32'(crr_q) + k) % NumChannels);
            if (!data_gnt_vld && elig[d_idx]) begin
                data_gnt_vld = 1'b1;
                data_gnt     = d_idx;
            end
            if (!cred_gnt_vld && has_pend[c_idx]) begin
                cred_gnt_vld = 1'b1;
                cred_gnt     = c_idx;
            end
        end
        if (do_data) begin
            tx_d.flit_vld           = 1'b1;
            tx_d.flit_ch            = data_gnt;
            tx_d.data               = ch_in_data_i[32'(data_gnt)*FlitWidth +: FlitWidth];
            ch_in_ready_o[data_gnt] = 1'b1;
        end
        if (do_cred) begin
            tx_d.cred_vld = 1'b1;
            tx_d.cred_ch  = cred_gnt;
        end
    end

    // Per-channel counter events and error detection
    always_comb begin
        cred_inc = '0;
        cred_dec = '0;
        cred_sat = '0;
        pend_dec = '0;
        push     = '0;
        drop     = '0;
        pop      = '0;
        for (int unsigned i = 0; i < NumChannels; i++) begin
            cred_inc[i] = rx_acc && rx_beat.cred_vld && (rx_beat.cred_ch == ChIdW'(i));
            cred_dec[i] = do_data && (data_gnt == ChIdW'(i));
            cred_sat[i] = cred_inc[i] && !cred_dec[i] && (credit_q[i] == CntW'(RxFifoDepth));
            pend_dec[i] = do_cred && (cred_gnt == ChIdW'(i));
            pop[i]      = (fifo_cnt_q[i] != '0) && ch_out_ready_i[i];
            push[i]     = rx_acc && rx_beat.flit_vld && (rx_beat.flit_ch == ChIdW'(i))
                          && (fifo_cnt_q[i] != CntW'(RxFifoDepth));
            drop[i]     = rx_acc && rx_beat.flit_vld && (rx_beat.flit_ch == ChIdW'(i))
                          && (fifo_cnt_q[i] == CntW'(RxFifoDepth));
        end
        bad_ch  = rx_acc && rx_beat.flit_vld && (32'(rx_beat.flit_ch) >= NumChannels);
        ovf_set = bad_ch || (|drop) || (|cred_sat);
    end

    // TX beat register, arbiter pointers, credit and pending-credit counters
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_vld_q   <= 1'b0;
            tx_q       <= '0;
            rr_q       <= '0;
            crr_q      <= '0;
            overflow_q <= 1'b0;
            for (int unsigned i = 0; i < NumChannels; i++) begin
                credit_q[i] <= CntW'(RxFifoDepth);
                pend_q[i]   <= '0;
            end
        end else begin
            if (do_data || do_cred) begin
                tx_vld_q <= 1'b1;
                tx_q     <= tx_d;
            end else if (axis_out_tready_i) begin
                tx_vld_q <= 1'b0;
                tx_q     <= '0;
            end
            if (do_data) begin
                rr_q <= (data_gnt == ChIdW'(NumChannels - 1)) ? '0 : data_gnt + ChIdW'(1);
            end
            if (do_cred) begin
                crr_q <= (cred_gnt == ChIdW'(NumChannels - 1)) ? '0 : cred_gnt + ChIdW'(1);
            end
            if (ovf_set) begin
                overflow_q <= 1'b1;
            end
            for (int unsigned i = 0; i < NumChannels; i++) begin
                if (cred_inc[i] && !cred_dec[i] && !cred_sat[i]) begin
                    credit_q[i] <= credit_q[i] + CntW'(1);
                end else if (cred_dec[i] && !cred_inc[i]) begin
                    credit_q[i] <= credit_q[i] - CntW'(1);
                end
                if (pop[i] && !pend_dec[i]) begin
                    pend_q[i] <= pend_q[i] + CntW'(1);
                end else if (pend_dec[i] && !pop[i]) begin
                    pend_q[i] <= pend_q[i] - CntW'(1);
                end
            end
        end
    end

    // RX FIFO pointers and occupancy
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NumChannels; i++) begin
                rd_ptr_q[i]   <= '0;
                wr_ptr_q[i]   <= '0;
                fifo_cnt_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NumChannels; i++) begin
                if (push[i]) wr_ptr_q[i] <= ptr_inc(wr_ptr_q[i]);
                if (pop[i])  rd_ptr_q[i] <= ptr_inc(rd_ptr_q[i]);
                if (push[i] && !pop[i]) begin
                    fifo_cnt_q[i] <= fifo_cnt_q[i] + CntW'(1);
                end else if (pop[i] && !push[i]) begin
                    fifo_cnt_q[i] <= fifo_cnt_q[i] - CntW'(1);
                end
            end
        end
    end

    // Storage needs no reset: data outputs are masked while the FIFO is empty
    always_ff @(posedge clk_i) begin
        for (int unsigned i = 0; i < NumChannels; i++) begin
            if (push[i]) fifo_mem[i][wr_ptr_q[i]] <= rx_beat.data;
        end
    end

    always_comb begin
        ch_out_valid_o = '0;
        ch_out_data_o  = '0;
        for (int unsigned i = 0; i < NumChannels; i++) begin
            ch_out_valid_o[i] = (fifo_cnt_q[i] != '0);
            if (ch_out_valid_o[i]) begin
                ch_out_data_o[i*FlitWidth +: FlitWidth] = fifo_mem[i][rd_ptr_q[i]];
            end
        end
    end

endmodule

// File: tb/tb_floo_axis_noc_bridge_vc_credit.sv
// Bench for floo_axis_noc_bridge_vc_credit: 4 channels, 16-bit flits, depth-4 RX FIFOs.
// Outgoing beats are checked against a queue of expected beats filled when stimulus is driven.
module tb_floo_axis_noc_bridge_vc_credit;

    localparam int unsigned N  = 4;
    localparam int unsigned FW = 16;
    localparam int unsigned CW = 2;
    localparam int unsigned BW = FW + 2 * CW + 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      in_valid, in_ready, out_valid, out_ready;
    logic [N*FW-1:0]   in_data, out_data;
    logic              ax_o_v, ax_o_r, ax_i_v, ax_i_r, ovf;
    logic [BW-1:0]     ax_o_d, ax_i_d;

    int                n_tests = 0;
    int                n_fail  = 0;
    logic [BW-1:0]     exp_q[$];
    logic [BW-1:0]     mon_exp;
    logic [BW-1:0]     bp_exp;

    typedef struct {
        int            ch;
        logic [FW-1:0] data;
        logic [N-1:0]  exp_valid;
        logic [FW-1:0] exp_data;
    } rx_vec_t;

    rx_vec_t vecs[5];

    always #5 clk = ~clk;

    floo_axis_noc_bridge_vc_credit #(
        .NumChannels (N),
        .FlitWidth   (FW),
        .RxFifoDepth (4)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .ch_in_valid_i     (in_valid),
        .ch_in_ready_o     (in_ready),
        .ch_in_data_i      (in_data),
        .ch_out_valid_o    (out_valid),
        .ch_out_ready_i    (out_ready),
        .ch_out_data_o     (out_data),
        .axis_out_tvalid_o (ax_o_v),
        .axis_out_tready_i (ax_o_r),
        .axis_out_tdata_o  (ax_o_d),
        .axis_in_tvalid_i  (ax_i_v),
        .axis_in_tready_o  (ax_i_r),
        .axis_in_tdata_i   (ax_i_d),
        .overflow_o        (ovf)
    );

    function automatic logic [BW-1:0] mk_beat(input logic fv, input logic [CW-1:0] fch,
                                              input logic cv, input logic [CW-1:0] cch,
                                              input logic [FW-1:0] d);
        return {d, cch, cv, fch, fv};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        out_ready = '0;
        ax_i_v    = 1'b0;
        ax_i_d    = '0;
        ax_o_r    = 1'b1;
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Every accepted outgoing beat must match the head of the expected queue
    always @(negedge clk) begin
        if (!rst && ax_o_v && ax_o_r) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_beat: got %h expected none", ax_o_d);
            end else begin
                mon_exp = exp_q.pop_front();
                check("axis_beat", 64'(ax_o_d), 64'(mon_exp));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{0, 16'hA5A5, 4'b0001, 16'hA5A5};
        vecs[1] = '{3, 16'h1234, 4'b1000, 16'h1234};
        vecs[2] = '{1, 16'hFFFF, 4'b0010, 16'hFFFF};
        vecs[3] = '{2, 16'h0001, 4'b0100, 16'h0001};
        vecs[4] = '{3, 16'h8000, 4'b1000, 16'h8000};

        // Reset and idle
        rst = 1'b1; in_valid = '0; in_data = '0; out_ready = '0;
        ax_i_v = 1'b0; ax_i_d = '0; ax_o_r = 1'b1;
        tick();
        mid();
        check("rst_axis_in_tready", 64'(ax_i_r), 64'(0));
        tick();
        rst = 1'b0;
        mid();
        check("rst_in_ready", 64'(in_ready), 64'(0));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_data", 64'(out_data), 64'(0));
        check("rst_tvalid", 64'(ax_o_v), 64'(0));
        check("rst_tdata", 64'(ax_o_d), 64'(0));
        check("rst_overflow", 64'(ovf), 64'(0));
        check("idle_axis_in_tready", 64'(ax_i_r), 64'(1));
        repeat (4) tick();
        mid();
        check("idle_no_beat", 64'(ax_o_v), 64'(0));

        // Table: single incoming flits, then a pop that returns a credit-only beat
        for (int v = 0; v < 5; v++) begin
            tick();
            ax_i_v = 1'b1;
            ax_i_d = mk_beat(1'b1, CW'(vecs[v].ch), 1'b0, '0, vecs[v].data);
            tick();
            ax_i_v = 1'b0;
            ax_i_d = '0;
            mid();
            check("rx_valid", 64'(out_valid), 64'(vecs[v].exp_valid));
            check("rx_data", 64'(out_data[vecs[v].ch*FW +: FW]), 64'(vecs[v].exp_data));
            tick();
            out_ready[vecs[v].ch] = 1'b1;
            exp_q.push_back(mk_beat(1'b0, '0, 1'b1, CW'(vecs[v].ch), '0));
            tick();
            out_ready = '0;
            mid();
            check("rx_popped", 64'(out_valid), 64'(0));
            repeat (3) tick();
        end
        check("rx_sb_drained", 64'(exp_q.size()), 64'(0));

        // Credit exhaustion on channel 1, then one returned credit
        do_reset();
        begin
            int            sent;
            logic [FW-1:0] d;
            sent = 0;
            d    = 16'h5000;
            in_valid[1]      = 1'b1;
            in_data[FW+:FW]  = d;
            repeat (8) begin
                mid();
                if (in_ready[1]) begin
                    exp_q.push_back(mk_beat(1'b1, CW'(1), 1'b0, '0, d));
                    sent++;
                    d++;
                end
                tick();
                in_data[FW+:FW] = d;
            end
            check("cred_beats_before_stall", 64'(sent), 64'(4));
            ax_i_v = 1'b1;
            ax_i_d = mk_beat(1'b0, '0, 1'b1, CW'(1), '0);
            mid();
            check("cred_stalled_ready", 64'(in_ready), 64'(0));
            tick();
            ax_i_v = 1'b0;
            ax_i_d = '0;
            mid();
            check("cred_returned_ready", 64'(in_ready), 64'(4'b0010));
            exp_q.push_back(mk_beat(1'b1, CW'(1), 1'b0, '0, 16'h5004));
            tick();
            mid();
            check("cred_fifth_beat_valid", 64'(ax_o_v), 64'(1));
            check("cred_exhausted_again", 64'(in_ready), 64'(0));
            tick();
            in_valid = '0;
            tick();
            check("cred_sb_drained", 64'(exp_q.size()), 64'(0));
        end

        // Round-robin across four channels with wrap-around
        do_reset();
        in_valid = '1;
        for (int i = 0; i < int'(N); i++) in_data[i*FW +: FW] = FW'(16'hC000 | i);
        begin
            int exp_ch;
            exp_ch = 0;
            for (int k = 0; k < 5; k++) begin
                mid();
                check("rr_grant", 64'(in_ready), 64'(1) << exp_ch);
                if (k > 0) check("rr_tvalid", 64'(ax_o_v), 64'(1));
                exp_q.push_back(mk_beat(1'b1, CW'(exp_ch), 1'b0, '0, FW'(16'hC000 | exp_ch)));
                exp_ch = (exp_ch + 1) % int'(N);
                tick();
            end
        end
        in_valid = '0;
        mid();
        check("rr_last_tvalid", 64'(ax_o_v), 64'(1));
        tick();
        tick();
        check("rr_sb_drained", 64'(exp_q.size()), 64'(0));

        // Back-pressure: held beat stays stable, inputs are not accepted
        ax_o_r   = 1'b0;
        in_valid = 4'b0100;
        in_data[2*FW +: FW] = 16'hBEEF;
        mid();
        check("bp_load_ready", 64'(in_ready), 64'(4'b0100));
        bp_exp = mk_beat(1'b1, CW'(2), 1'b0, '0, 16'hBEEF);
        exp_q.push_back(bp_exp);
        tick();
        in_valid = 4'b1100;
        in_data[2*FW +: FW] = 16'hDEAD;
        repeat (3) begin
            mid();
            check("bp_ready_low", 64'(in_ready), 64'(0));
            check("bp_tvalid", 64'(ax_o_v), 64'(1));
            check("bp_tdata_stable", 64'(ax_o_d), 64'(bp_exp));
            tick();
        end
        in_valid = '0;
        ax_o_r   = 1'b1;
        tick();
        tick();
        check("bp_sb_drained", 64'(exp_q.size()), 64'(0));

        // Credit-only beat two cycles after a pop
        do_reset();
        ax_i_v = 1'b1;
        ax_i_d = mk_beat(1'b1, '0, 1'b0, '0, 16'h0F0F);
        tick();
        ax_i_v = 1'b0;
        ax_i_d = '0;
        tick();
        out_ready[0] = 1'b1;
        mid();
        check("co_fifo_valid", 64'(out_valid), 64'(4'b0001));
        exp_q.push_back(mk_beat(1'b0, '0, 1'b1, '0, '0));
        tick();
        out_ready = '0;
        mid();
        check("co_not_early", 64'(ax_o_v), 64'(0));
        tick();
        mid();
        check("co_visible", 64'(ax_o_v), 64'(1));
        check("co_tdata", 64'(ax_o_d), 64'(mk_beat(1'b0, '0, 1'b1, '0, '0)));
        tick();

        // Credit piggy-backs on a concurrent channel-1 data beat
        ax_i_v = 1'b1;
        ax_i_d = mk_beat(1'b1, '0, 1'b0, '0, 16'hF0F0);
        tick();
        ax_i_v = 1'b0;
        ax_i_d = '0;
        tick();
        out_ready[0] = 1'b1;
        tick();
        out_ready = '0;
        in_valid[1] = 1'b1;
        in_data[FW +: FW] = 16'h7777;
        mid();
        check("pb_ready", 64'(in_ready), 64'(4'b0010));
        exp_q.push_back(mk_beat(1'b1, CW'(1), 1'b1, '0, 16'h7777));
        tick();
        in_valid = '0;
        mid();
        check("pb_tvalid", 64'(ax_o_v), 64'(1));
        repeat (3) tick();
        check("pb_sb_drained", 64'(exp_q.size()), 64'(0));

        // FIFO overflow on channel 2, sticky flag, in-order drain
        do_reset();
        for (int k = 0; k < 4; k++) begin
            ax_i_v = 1'b1;
            ax_i_d = mk_beat(1'b1, CW'(2), 1'b0, '0, FW'(16'hE000 + k));
            tick();
        end
        ax_i_v = 1'b0;
        mid();
        check("ovf_before_fifth", 64'(ovf), 64'(0));
        check("ovf_fifo_valid", 64'(out_valid), 64'(4'b0100));
        ax_i_v = 1'b1;
        ax_i_d = mk_beat(1'b1, CW'(2), 1'b0, '0, 16'hE004);
        tick();
        ax_i_v = 1'b0;
        ax_i_d = '0;
        mid();
        check("ovf_set", 64'(ovf), 64'(1));
        repeat (3) tick();
        mid();
        check("ovf_sticky", 64'(ovf), 64'(1));
        tick();
        out_ready[2] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            mid();
            check("ovf_drain_valid", 64'(out_valid[2]), 64'(k < 4));
            if (k < 4) begin
                check("ovf_drain_data", 64'(out_data[2*FW +: FW]), 64'(16'hE000 + k));
                exp_q.push_back(mk_beat(1'b0, '0, 1'b1, CW'(2), '0));
            end
            tick();
        end
        out_ready = '0;
        repeat (4) tick();
        check("ovf_sb_drained", 64'(exp_q.size()), 64'(0));
        mid();
        check("ovf_still_set", 64'(ovf), 64'(1));
        do_reset();
        mid();
        check("ovf_cleared_by_reset", 64'(ovf), 64'(0));

        // Credit arriving for a full counter sets overflow
        tick();
        ax_i_v = 1'b1;
        ax_i_d = mk_beat(1'b0, '0, 1'b1, '0, '0);
        tick();
        ax_i_v = 1'b0;
        ax_i_d = '0;
        mid();
        check("cred_ovf_set", 64'(ovf), 64'(1));
        check("cred_ovf_no_beat", 64'(ax_o_v), 64'(0));
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/floo_axis_noc_bridge_vc_credit.md
# floo_axis_noc_bridge_vc_credit

Parametrised, credit-flow-controlled bridge between `NumChannels` NoC virtual channels and a single AXI-Stream link. Outgoing flits are arbitrated round-robin onto the link, each carrying a channel ID. Per-channel credits guarantee that the remote receive FIFO never overflows. Credits are returned piggy-backed on data beats or in credit-only beats. The block sits between the NoC router ports and the serial-link AXIS interface and replaces the fixed two-channel request/response bridge.

## Interface
- `NumChannels`, 2: number of virtual channels, ≥2.
- `FlitWidth`, 64: flit payload bits per channel.
- `RxFifoDepth`, 4: per-channel receive FIFO depth, ≥2. It is also the initial credit count.
- `ChIdW`, derived: max(1, $clog2(NumChannels)).
- `BeatWidth`, derived: FlitWidth + 2*ChIdW + 2.
- `CntW`, derived: $clog2(RxFifoDepth+1).
- `clk_i`  in  1  clock; all logic on the rising edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `ch_in_valid_i`  in  NumChannels  per-channel flit valid, NoC → link.
- `ch_in_ready_o`  out  NumChannels  per-channel flit accept.
- `ch_in_data_i`  in  NumChannels*FlitWidth  flits; channel i occupies slice [i*FlitWidth +: FlitWidth].
- `ch_out_valid_o`  out  NumChannels  per-channel flit valid, link → NoC.
- `ch_out_ready_i`  in  NumChannels  per-channel pop.
- `ch_out_data_o`  out  NumChannels*FlitWidth  received flits.
- `axis_out_tvalid_o` / `axis_out_tready_i` / `axis_out_tdata_o`  out / in / out  1 / 1 / BeatWidth  outgoing beats.
- `axis_in_tvalid_i` / `axis_in_tready_o` / `axis_in_tdata_i`  in / out / in  1 / 1 / BeatWidth  incoming beats.
- `overflow_o`  out  1  sticky error: a flit arrived for a full FIFO, or a credit arrived for a full counter.

## Operation
- Beat layout, LSB first:
  - bit 0: `flit_vld`
  - [ChIdW:1]: `flit_ch`
  - bit ChIdW+1: `cred_vld`
  - next ChIdW bits: `cred_ch`
  - top FlitWidth bits: flit data
- Unused fields are driven to 0.
- TX credit counters `credit[i]` (CntW bits):
  - reset to RxFifoDepth;
  - −1 when a flit of channel i is loaded into the TX register;
  - +1 when an accepted incoming beat has cred_vld=1 and cred_ch=i;
  - a simultaneous −1 and +1 leaves the counter unchanged;
  - +1 at RxFifoDepth saturates and sets `overflow_o`.
- Eligibility: channel i is eligible when ch_in_valid_i[i]=1 and credit[i]>0.
- Data arbiter:
  - round-robin over eligible channels, starting at `rr_ptr`;
  - on a grant to channel g, rr_ptr ← (g+1) mod NumChannels; it wraps from NumChannels−1 to 0;
  - rr_ptr does not advance without a grant.
- TX register:
  - one beat; loads when empty or when it is being accepted (tvalid & tready);
  - ch_in_ready_o[g]=1 only for the granted channel in a load cycle; otherwise 0.
- Pending-credit counters `pend[i]`:
  - +1 when FIFO i pops (ch_out_valid_o[i] & ch_out_ready_i[i]);
  - −1 when a loaded beat carries cred_ch=i;
  - simultaneous +1/−1 leaves the counter unchanged.
- Credit arbiter:
  - separate round-robin pointer over channels with pend>0;
  - attaches at most one credit to every loaded beat.
- A credit-only beat (flit_vld=0, cred_vld=1) is loaded when no channel is eligible, some pend>0, and the register can load.
- A beat with flit_vld=0 and cred_vld=0 is never emitted.
- RX path:
  - axis_in_tready_o=1 whenever not in reset;
  - flit_vld=1 pushes flit data into FIFO[flit_ch];
  - a push into a full FIFO drops the flit and sets overflow_o;
  - flit_ch ≥ NumChannels is ignored and sets overflow_o.
- FIFOs: per channel, depth RxFifoDepth, registered output (not fall-through).

## Timing
- Reset state:
  - all valid/ready outputs 0, overflow_o 0, data outputs 0;
  - credits = RxFifoDepth; pend = 0; FIFOs empty; both rr pointers 0.
- Reset asserted mid-operation takes effect at the next edge and discards in-flight beats, FIFO contents and counters.
- TX latency: flit accepted (valid&ready) in cycle N → axis_out_tvalid_o=1 from cycle N+1. Full throughput is one beat per cycle while tready=1.
- AXIS rule: once tvalid_o=1, tdata_o stays stable until tready_i=1.
- RX latency:
  - beat accepted in cycle N → ch_out_valid_o[ch]=1 in cycle N+1;
  - a credit received in cycle N is usable for eligibility in cycle N+1.
- Credit return latency: pop in cycle N → earliest beat carrying that credit is visible in cycle N+2.

## Test plan
- Reset, then idle: all outputs 0, credit counters read 4 (RxFifoDepth=4), no beats emitted.
- Channel 1 sends 5 flits with the remote returning no credits: 4 beats with flit_ch=1, then ch_in_ready_o[1]=0. One incoming credit for ch1 → 5th beat emitted 2 cycles later.
- NumChannels=4, all channels valid, credits plentiful, tready=1: flit_ch sequence 0,1,2,3,0 (wrap-around), one beat per cycle.
- tready held 0 for 3 cycles with a beat pending: tdata_o stable across all 3 cycles; ch_in_ready_o all 0.
- Incoming flit for ch0 popped at cycle 10 with no outgoing traffic: credit-only beat {flit_vld=0, cred_vld=1, cred_ch=0} visible at cycle 12. With simultaneous ch1 data, the credit rides on the ch1 data beat instead.
- 5 incoming ch2 flits without pops (depth 4): 5th flit dropped, overflow_o=1 and it stays 1 until reset.
